sram_arb_2p: RTL and testbench
==============================

SRAM_ARB_2P -- requirements
Module: sram_arb_2p

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max ACCESS cycles waiting for memory done before error.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports a_req/b_req  input  1  request valid, held until grant.
REQ-005 SHALL have ports a_we/b_we  input  1  1=write, 0=read.
REQ-006 SHALL have ports a_addr/b_addr  input  5  word address 0..31.
REQ-007 SHALL have ports a_wdata/b_wdata  input  8  write data.
REQ-008 SHALL have ports a_gnt/b_gnt  output  1  one-cycle accept pulse.
REQ-009 SHALL have ports a_done/b_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports a_rdata/b_rdata  output  8  read data, valid with done.
REQ-011 SHALL have ports a_err/b_err  output  1  timeout flag, valid with done.
REQ-012 SHALL have ports mem_read, mem_write  output  1  SRAM strobes.
REQ-013 SHALL have ports mem_read_addr, mem_write_addr  output  8  {3'b000, addr}.
REQ-014 SHALL have port mem_wr_data  output  8  latched write data.
REQ-015 SHALL have ports mem_rd_data  input  8, mem_rd_done, mem_wr_done  input  1  SRAM response.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; requests sampled only in IDLE.
REQ-017 In IDLE with any req at an edge, SHALL latch winner's we/addr/wdata, enter ACCESS, assert winner's gnt for exactly that first ACCESS cycle.
REQ-018 Simultaneous a_req and b_req SHALL grant the port not granted last (round-robin); single requester SHALL always win.
REQ-019 In ACCESS, exactly one of mem_read/mem_write SHALL be held high per latched we; address and data stable throughout.
REQ-020 ACCESS SHALL exit to RESP on the edge sampling mem_rd_done (read) or mem_wr_done (write); the other done input SHALL be ignored.
REQ-021 ACCESS cycle counter (4 bits minimum, saturating) SHALL force RESP with err=1 when it reaches TIMEOUT cycles without done.
REQ-022 In RESP (one cycle), strobes SHALL be low; owner's done=1, rdata=captured mem_rd_data for successful reads, 8'h00 for writes and timeouts; err per REQ-021.
REQ-023 rdata/err SHALL hold their value until the owner's next done.
REQ-024 Minimum latency: req sampled edge E0, gnt after E0, done pulse after E0+1 when memory answers at E1; 3 cycles per access.
REQ-025 Non-owner done/gnt SHALL remain 0; a req dropped before grant SHALL be discarded.
REQ-026 Address upper SRAM bits SHALL always be 0 (no wrap beyond 31).

Reset
REQ-027 rst high SHALL asynchronously force IDLE, all outputs 0 (strobes, gnt, done, err, rdata, mem buses), counter 0, last-grant = B (A wins first tie).
REQ-028 Reset mid-ACCESS SHALL drop strobes immediately; aborted request SHALL produce no done.

Structure
REQ-029 Shared package sram_ctrl_pkg SHALL hold state encodings (IDLE=0, ACCESS=1, RESP=2), ADDR_W=5, MEM_ADDR_W=8, DATA_W=8.
REQ-030 Round-robin selection SHALL be sub-module sram_rr_pick2 (inputs req pair, last-grant; output winner); remainder in top.

Verification
REQ-031 A writes 8'hFA to addr 0, SRAM answers -> a_gnt one pulse, mem_write=1 with mem_write_addr=8'h00, a_done, a_err=0; A reads addr 0 -> a_rdata=8'hFA.
REQ-032 B writes 8'h5E to addr 7, A reads addr 7 -> mem_read_addr=8'h07, a_rdata=8'h5E, b_rdata unchanged.
REQ-033 a_req and b_req held high for 4 accesses from reset -> grant order A,B,A,B; no overlapping strobes.
REQ-034 mem_rd_done tied 0, A read -> a_done with a_err=1, a_rdata=8'h00 after 15 ACCESS cycles; next access proceeds normally.
REQ-035 rst pulsed during ACCESS -> strobes low same cycle, no done, FSM IDLE; next tied request granted to A.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encodings, widths, port ids.
// Pure declarations, no logic and no latency.
// No flow control of its own.
package sram_ctrl_pkg;

  localparam int ADDR_W     = 5;
  localparam int MEM_ADDR_W = 8;
  localparam int DATA_W     = 8;

  // Requester identity, also used as the last-grant / owner encoding.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The SRAM is wider than the 32-word window we expose, so the upper
  // address bits are always driven to zero.
  function automatic logic [MEM_ADDR_W-1:0] mem_addr(input logic [ADDR_W-1:0] addr);
    return {{(MEM_ADDR_W - ADDR_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/sram_rr_pick2.sv
// Two-way round-robin picker: chooses A or B among active requests.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the choice is consumed.
module sram_rr_pick2
  import sram_ctrl_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_gnt,
  output logic winner
);

  // A lone requester always wins; on a tie the port not granted last wins.
  always_comb begin
    winner = PORT_A;
    if (a_req && b_req) begin
      winner = (last_gnt == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      winner = PORT_B;
    end
  end

endmodule

// File: rtl/sram_arb_2p.sv
// Two-port arbiter serialising A/B word accesses onto one SRAM, with timeout.
// Latency: gnt one cycle after request sampled, done one cycle after memory done (3 cycles min).
// Backpressure: requests are held until gnt; only sampled in IDLE, dropped requests are ignored.
module sram_arb_2p
  import sram_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_err,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  b_gnt,
  output logic                  b_done,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_err,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_read_addr,
  output logic [MEM_ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0]     mem_wr_data,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic                  mem_rd_done,
  input  logic                  mem_wr_done
);

  // Counter is at least 4 bits, wider only if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  state_t              state;
  state_t              state_nxt;

  logic                last_gnt;
  logic                winner;
  logic                owner;

  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;

  logic                take;
  logic                fin_ok;
  logic                fin_to;
  logic [DATA_W-1:0]   rsp_data;

  sram_rr_pick2 u_pick (
    .a_req    (a_req),
    .b_req    (b_req),
    .last_gnt (last_gnt),
    .winner   (winner)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the transaction events that the datapath registers act on.
  // Only the done input matching the latched direction is looked at.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          take      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q ? mem_wr_done : mem_rd_done) begin
          fin_ok    = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          fin_to    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data is only meaningful for a successful read; writes and timeouts return zero.
  always_comb begin
    rsp_data = '0;
    if (fin_ok && !we_q) begin
      rsp_data = mem_rd_data;
    end
  end

  // Latch the winner's command when it is accepted and remember who got the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= PORT_B;
      owner    <= PORT_A;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (take) begin
      last_gnt <= winner;
      owner    <= winner;
      we_q     <= (winner == PORT_B) ? b_we    : a_we;
      addr_q   <= (winner == PORT_B) ? b_addr  : a_addr;
      wdata_q  <= (winner == PORT_B) ? b_wdata : a_wdata;
    end
  end

  // Grant pulses during the first ACCESS cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
    end else begin
      a_gnt <= take && (winner == PORT_A);
      b_gnt <= take && (winner == PORT_B);
    end
  end

  // Count elapsed ACCESS cycles; saturates so a huge TIMEOUT cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state != ACCESS) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Completion: done pulses in RESP; rdata/err are held per port until that port's next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      if (fin_ok || fin_to) begin
        if (owner == PORT_A) begin
          a_done  <= 1'b1;
          a_err   <= fin_to;
          a_rdata <= rsp_data;
        end else begin
          b_done  <= 1'b1;
          b_err   <= fin_to;
          b_rdata <= rsp_data;
        end
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign mem_read       = (state == ACCESS) && !we_q;
  assign mem_write      = (state == ACCESS) &&  we_q;
  assign mem_read_addr  = mem_addr(addr_q);
  assign mem_write_addr = mem_addr(addr_q);
  assign mem_wr_data    = wdata_q;

  // Structural invariants of the arbiter.
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
  a_gnt_excl:    assert property (@(posedge clk) disable iff (rst) !(a_gnt && b_gnt));
  a_done_excl:   assert property (@(posedge clk) disable iff (rst) !(a_done && b_done));

endmodule

// File: tb/tb_sram_arb_2p.sv
module tb_sram_arb_2p;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_read_addr, mem_write_addr, mem_wr_data, mem_rd_data;
  logic       mem_rd_done, mem_wr_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_arb_2p #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done)
  );

  // ---------------- SRAM environment ----------------
  bit         sram_en   = 1'b1;
  bit         sram_swap = 1'b0;
  int         sram_lat  = 1;
  int         acc       = 0;
  logic [7:0] sram [32];

  always @(negedge clk) begin
    mem_rd_done = 1'b0;
    mem_wr_done = 1'b0;
    mem_rd_data = 8'($urandom);
    if (!(mem_read || mem_write)) begin
      acc = 0;
    end else begin
      acc++;
      if (sram_en && acc == sram_lat) begin
        if (mem_write) begin
          if (!sram_swap) begin
            sram[mem_write_addr[4:0]] = mem_wr_data;
            mem_wr_done = 1'b1;
          end else begin
            mem_rd_done = 1'b1;
          end
        end else begin
          if (!sram_swap) begin
            mem_rd_data = sram[mem_read_addr[4:0]];
            mem_rd_done = 1'b1;
          end else begin
            mem_wr_done = 1'b1;
          end
        end
      end
    end
  end

  int overlap_cnt = 0;
  int addr_hi_bad = 0;
  int done_total  = 0;

  always @(posedge clk) begin
    #1;
    if (mem_read && mem_write) overlap_cnt++;
    if ((mem_read || mem_write) && (mem_read_addr[7:5] != 3'b000 || mem_write_addr[7:5] != 3'b000))
      addr_hi_bad++;
    if (a_done || b_done) done_total++;
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [32];
  logic       exp_last;
  logic [7:0] exp_rd_a, exp_rd_b;
  logic       exp_err_a, exp_err_b;

  task automatic model_reset();
    exp_last  = 1'b1;
    exp_rd_a  = 8'h00;
    exp_rd_b  = 8'h00;
    exp_err_a = 1'b0;
    exp_err_b = 1'b0;
  endtask

  // One completed access by port p (0=A,1=B); ok=0 means it timed out.
  task automatic model_apply(input logic p, input logic we, input logic [4:0] ad,
                             input logic [7:0] wd, input logic ok);
    logic [7:0] r;
    r = 8'h00;
    if (ok && we)  ref_mem[ad] = wd;
    if (ok && !we) r = ref_mem[ad];
    exp_last = p;
    if (p) begin exp_rd_b = r; exp_err_b = !ok; end
    else   begin exp_rd_a = r; exp_err_a = !ok; end
  endtask

  // ---------------- stimulus / observation ----------------
  logic       obs_order [$];
  logic       obs_done_a, obs_done_b, obs_err_a, obs_err_b;
  logic [7:0] obs_rd_a, obs_rd_b;
  int         obs_cyc_a, obs_cyc_b, obs_gnt_a, obs_gnt_b, obs_stray;
  logic       obs_s_rd, obs_s_wr;
  logic [7:0] obs_s_addr, obs_s_wdata;

  function automatic logic [3:0] order_code();
    logic [3:0] c;
    c = 4'h0;
    c[3:2] = 2'(obs_order.size());
    if (obs_order.size() > 0) c[1] = obs_order[0];
    if (obs_order.size() > 1) c[0] = obs_order[1];
    return c;
  endfunction

  task automatic run_pair(input logic en_a, input logic en_b,
                          input logic wa, input logic [4:0] ada, input logic [7:0] wda,
                          input logic wb, input logic [4:0] adb, input logic [7:0] wdb);
    int   k, ga, gb;
    logic drop_a, drop_b;
    obs_order.delete();
    obs_done_a = 0; obs_done_b = 0; obs_gnt_a = 0; obs_gnt_b = 0; obs_stray = 0;
    obs_cyc_a = -1; obs_cyc_b = -1; obs_rd_a = 8'hxx; obs_rd_b = 8'hxx;
    obs_err_a = 1'bx; obs_err_b = 1'bx;
    ga = 0; gb = 0; k = 0; drop_a = 0; drop_b = 0;
    @(negedge clk);
    a_we = wa; a_addr = ada; a_wdata = wda; a_req = en_a;
    b_we = wb; b_addr = adb; b_wdata = wdb; b_req = en_b;
    while (k < 2 * (TO + 8) && ((en_a && !obs_done_a) || (en_b && !obs_done_b))) begin
      @(posedge clk); #1; k++;
      if (a_gnt) begin
        obs_order.push_back(1'b0); obs_gnt_a++; ga = k; drop_a = 1;
        obs_s_rd = mem_read; obs_s_wr = mem_write; obs_s_wdata = mem_wr_data;
        obs_s_addr = mem_read ? mem_read_addr : mem_write_addr;
      end
      if (b_gnt) begin
        obs_order.push_back(1'b1); obs_gnt_b++; gb = k; drop_b = 1;
        obs_s_rd = mem_read; obs_s_wr = mem_write; obs_s_wdata = mem_wr_data;
        obs_s_addr = mem_read ? mem_read_addr : mem_write_addr;
      end
      if (a_done) begin
        if (!en_a || obs_done_a || ga == 0) obs_stray++;
        else begin obs_done_a = 1; obs_rd_a = a_rdata; obs_err_a = a_err; obs_cyc_a = k - ga; end
      end
      if (b_done) begin
        if (!en_b || obs_done_b || gb == 0) obs_stray++;
        else begin obs_done_b = 1; obs_rd_b = b_rdata; obs_err_b = b_err; obs_cyc_b = k - gb; end
      end
      @(negedge clk);
      if (drop_a) a_req = 1'b0;
      if (drop_b) b_req = 1'b0;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000000",
                        {a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write});
    end
    n_cmp++;
    if ({a_rdata, b_rdata, mem_read_addr, mem_write_addr, mem_wr_data} !== 40'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0",
                        {a_rdata, b_rdata, mem_read_addr, mem_write_addr, mem_wr_data});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (done_total !== 0) begin
      n_bad++; $display("FAIL idle_no_done: got %0d expected 0", done_total);
    end
  endtask

  task automatic test_write_read();
    sram_lat = 1;
    run_pair(1, 0, 1'b1, 5'd0, 8'hFA, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b1, 5'd0, 8'hFA, 1'b1);
    n_cmp++;
    if (obs_gnt_a !== 1) begin n_bad++; $display("FAIL wr_gnt_count: got %0d expected 1", obs_gnt_a); end
    n_cmp++;
    if ({obs_s_wr, obs_s_rd} !== 2'b10) begin n_bad++; $display("FAIL wr_strobe: got %b expected 10", {obs_s_wr, obs_s_rd}); end
    n_cmp++;
    if (obs_s_addr !== 8'h00) begin n_bad++; $display("FAIL wr_addr: got %h expected 00", obs_s_addr); end
    n_cmp++;
    if (obs_s_wdata !== 8'hFA) begin n_bad++; $display("FAIL wr_data: got %h expected fa", obs_s_wdata); end
    n_cmp++;
    if ({obs_done_a, obs_err_a} !== {1'b1, exp_err_a}) begin
      n_bad++; $display("FAIL wr_done_err: got %b expected %b", {obs_done_a, obs_err_a}, {1'b1, exp_err_a});
    end
    n_cmp++;
    if (obs_cyc_a !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d expected 1", obs_cyc_a); end
    run_pair(1, 0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    n_cmp++;
    if ({obs_s_wr, obs_s_rd} !== 2'b01) begin n_bad++; $display("FAIL rd_strobe: got %b expected 01", {obs_s_wr, obs_s_rd}); end
    n_cmp++;
    if (obs_rd_a !== exp_rd_a) begin n_bad++; $display("FAIL rd_data: got %h expected %h", obs_rd_a, exp_rd_a); end
  endtask

  task automatic test_cross_port();
    run_pair(0, 1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'h5E);
    model_apply(1'b1, 1'b1, 5'd7, 8'h5E, 1'b1);
    n_cmp++;
    if ({obs_done_b, obs_err_b, obs_gnt_a} !== {1'b1, 1'b0, 32'd0}) begin
      n_bad++; $display("FAIL b_write: got done=%b err=%b a_gnts=%0d expected 1 0 0", obs_done_b, obs_err_b, obs_gnt_a);
    end
    run_pair(1, 0, 1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd7, 8'h00, 1'b1);
    n_cmp++;
    if (obs_s_addr !== 8'h07) begin n_bad++; $display("FAIL cross_rd_addr: got %h expected 07", obs_s_addr); end
    n_cmp++;
    if (obs_rd_a !== exp_rd_a) begin n_bad++; $display("FAIL cross_rd_data: got %h expected %h", obs_rd_a, exp_rd_a); end
    n_cmp++;
    if (b_rdata !== exp_rd_b) begin n_bad++; $display("FAIL cross_b_hold: got %h expected %h", b_rdata, exp_rd_b); end
    n_cmp++;
    if (obs_stray !== 0) begin n_bad++; $display("FAIL cross_stray_done: got %0d expected 0", obs_stray); end
  endtask

  task automatic test_round_robin();
    logic got [$];
    int   kg [$];
    int   k, ov0;
    logic e;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    sram_lat = 1;
    ov0 = overlap_cnt;
    a_we = 1; a_addr = 5'd10; a_wdata = 8'h11;
    b_we = 1; b_addr = 5'd11; b_wdata = 8'h22;
    a_req = 1; b_req = 1;
    k = 0;
    while (got.size() < 4 && k < 100) begin
      @(posedge clk); #1; k++;
      if (a_gnt) begin got.push_back(1'b0); kg.push_back(k); end
      if (b_gnt) begin got.push_back(1'b1); kg.push_back(k); end
    end
    @(negedge clk);
    a_req = 0; b_req = 0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (got.size() !== 4) begin
      n_bad++; $display("FAIL rr_grants: got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = !exp_last;
        if (e) model_apply(e, 1'b1, 5'd11, 8'h22, 1'b1);
        else   model_apply(e, 1'b1, 5'd10, 8'h11, 1'b1);
        n_cmp++;
        if (got[i] !== e) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i], e); end
      end
      n_cmp++;
      if (kg[3] - kg[0] !== 9) begin n_bad++; $display("FAIL rr_throughput: got %0d expected 9", kg[3] - kg[0]); end
    end
    n_cmp++;
    if (overlap_cnt !== ov0) begin n_bad++; $display("FAIL rr_overlap: got %0d expected %0d", overlap_cnt, ov0); end
  endtask

  task automatic test_timeout();
    run_pair(1, 0, 1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd7, 8'h00, 1'b1);
    n_cmp++;
    if (a_rdata !== 8'h5E) begin n_bad++; $display("FAIL to_precond: got %h expected 5e", a_rdata); end
    sram_en = 0;
    run_pair(1, 0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    sram_en = 1;
    n_cmp++;
    if ({obs_done_a, obs_err_a, obs_rd_a} !== {1'b1, exp_err_a, exp_rd_a}) begin
      n_bad++; $display("FAIL to_resp: got done=%b err=%b rd=%h expected 1 %b %h", obs_done_a, obs_err_a, obs_rd_a, exp_err_a, exp_rd_a);
    end
    n_cmp++;
    if (obs_cyc_a !== TO) begin n_bad++; $display("FAIL to_cycles: got %0d expected %0d", obs_cyc_a, TO); end
    sram_lat = 3;
    run_pair(1, 0, 1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd7, 8'h00, 1'b1);
    n_cmp++;
    if ({obs_err_a, obs_rd_a, obs_cyc_a} !== {exp_err_a, exp_rd_a, 32'd3}) begin
      n_bad++; $display("FAIL to_recover: got err=%b rd=%h cyc=%0d expected %b %h 3", obs_err_a, obs_rd_a, obs_cyc_a, exp_err_a, exp_rd_a);
    end
  endtask

  task automatic test_wrong_done();
    sram_swap = 1; sram_lat = 2;
    run_pair(0, 1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 8'h77);
    model_apply(1'b1, 1'b1, 5'd3, 8'h77, 1'b0);
    n_cmp++;
    if ({obs_err_b, obs_rd_b, obs_cyc_b} !== {exp_err_b, exp_rd_b, TO}) begin
      n_bad++; $display("FAIL wrongdone_wr: got err=%b rd=%h cyc=%0d expected %b %h %0d", obs_err_b, obs_rd_b, obs_cyc_b, exp_err_b, exp_rd_b, TO);
    end
    run_pair(1, 0, 1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd7, 8'h00, 1'b0);
    n_cmp++;
    if ({obs_err_a, obs_rd_a, obs_cyc_a} !== {exp_err_a, exp_rd_a, TO}) begin
      n_bad++; $display("FAIL wrongdone_rd: got err=%b rd=%h cyc=%0d expected %b %h %0d", obs_err_a, obs_rd_a, obs_cyc_a, exp_err_a, exp_rd_a, TO);
    end
    sram_swap = 0; sram_lat = 1;
    run_pair(1, 0, 1'b0, 5'd3, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd3, 8'h00, 1'b1);
    n_cmp++;
    if ({obs_err_a, obs_rd_a} !== {exp_err_a, exp_rd_a}) begin
      n_bad++; $display("FAIL wrongdone_after: got err=%b rd=%h expected %b %h", obs_err_a, obs_rd_a, exp_err_a, exp_rd_a);
    end
  endtask

  task automatic test_reset_mid_access();
    int k, d0;
    logic [3:0] exp_code;
    run_pair(1, 0, 1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00);
    model_apply(1'b0, 1'b0, 5'd7, 8'h00, 1'b1);
    sram_en = 0;
    @(negedge clk);
    a_we = 0; a_addr = 5'd3; a_req = 1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!a_gnt && k < 10);
    n_cmp++;
    if (a_gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid_gnt: got %b expected 1", a_gnt); end
    @(negedge clk); a_req = 0;
    @(posedge clk); #2;
    n_cmp++;
    if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rstmid_active: got %b expected 1", mem_read); end
    d0 = done_total;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL rstmid_strobes: got %b expected 00", {mem_read, mem_write}); end
    repeat (2) @(negedge clk);
    rst = 1'b0; sram_en = 1;
    model_reset();
    repeat (TO + 4) @(posedge clk);
    #1;
    n_cmp++;
    if (done_total !== d0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d expected %0d", done_total, d0); end
    n_cmp++;
    if ({a_rdata, b_rdata, a_err, b_err} !== {exp_rd_a, exp_rd_b, exp_err_a, exp_err_b}) begin
      n_bad++; $display("FAIL rstmid_cleared: got %h %h %b %b expected 0", a_rdata, b_rdata, a_err, b_err);
    end
    run_pair(1, 1, 1'b0, 5'd7, 8'h00, 1'b0, 5'd3, 8'h00);
    exp_code = {2'd2, !exp_last, exp_last};
    model_apply(!exp_last, 1'b0, (!exp_last) ? 5'd3 : 5'd7, 8'h00, 1'b1);
    model_apply(!exp_last, 1'b0, (!exp_last) ? 5'd3 : 5'd7, 8'h00, 1'b1);
    n_cmp++;
    if (order_code() !== exp_code) begin n_bad++; $display("FAIL rstmid_tie: got %b expected %b", order_code(), exp_code); end
    n_cmp++;
    if ({obs_rd_a, obs_rd_b} !== {exp_rd_a, exp_rd_b}) begin
      n_bad++; $display("FAIL rstmid_tie_data: got %h %h expected %h %h", obs_rd_a, obs_rd_b, exp_rd_a, exp_rd_b);
    end
  endtask

  task automatic test_random();
    int         mode;
    logic       wa, wb, w;
    logic [4:0] ada, adb;
    logic [7:0] wda, wdb;
    logic [3:0] exp_code;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      sram_lat = $urandom_range(1, 4);
      wa = 1'($urandom); wb = 1'($urandom);
      ada = 5'($urandom_range(0, 7)); adb = 5'($urandom_range(0, 7));
      wda = 8'($urandom); wdb = 8'($urandom);
      run_pair(mode != 1, mode != 0, wa, ada, wda, wb, adb, wdb);
      if (mode == 2) begin
        w = !exp_last;
        exp_code = {2'd2, w, !w};
        if (w) begin model_apply(1'b1, wb, adb, wdb, 1'b1); model_apply(1'b0, wa, ada, wda, 1'b1); end
        else   begin model_apply(1'b0, wa, ada, wda, 1'b1); model_apply(1'b1, wb, adb, wdb, 1'b1); end
      end else if (mode == 1) begin
        exp_code = 4'b0110;
        model_apply(1'b1, wb, adb, wdb, 1'b1);
      end else begin
        exp_code = 4'b0100;
        model_apply(1'b0, wa, ada, wda, 1'b1);
      end
      n_cmp++;
      if (order_code() !== exp_code) begin n_bad++; $display("FAIL rnd_order[%0d]: got %b expected %b", it, order_code(), exp_code); end
      if (mode != 1) begin
        n_cmp++;
        if ({obs_rd_a, obs_err_a, obs_cyc_a} !== {exp_rd_a, exp_err_a, sram_lat}) begin
          n_bad++; $display("FAIL rnd_a[%0d]: got rd=%h err=%b cyc=%0d expected %h %b %0d", it, obs_rd_a, obs_err_a, obs_cyc_a, exp_rd_a, exp_err_a, sram_lat);
        end
      end
      if (mode != 0) begin
        n_cmp++;
        if ({obs_rd_b, obs_err_b, obs_cyc_b} !== {exp_rd_b, exp_err_b, sram_lat}) begin
          n_bad++; $display("FAIL rnd_b[%0d]: got rd=%h err=%b cyc=%0d expected %h %b %0d", it, obs_rd_b, obs_err_b, obs_cyc_b, exp_rd_b, exp_err_b, sram_lat);
        end
      end
      n_cmp++;
      if ({a_rdata, b_rdata, obs_stray} !== {exp_rd_a, exp_rd_b, 32'd0}) begin
        n_bad++; $display("FAIL rnd_hold[%0d]: got %h %h stray=%0d expected %h %h 0", it, a_rdata, b_rdata, obs_stray, exp_rd_a, exp_rd_b);
      end
    end
    n_cmp++;
    if ({overlap_cnt, addr_hi_bad} !== 64'd0) begin
      n_bad++; $display("FAIL global_invariants: got overlap=%0d addr_hi=%0d expected 0 0", overlap_cnt, addr_hi_bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      sram[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end
    model_reset();
    test_reset();
    test_write_read();
    test_cross_port();
    test_round_robin();
    test_cross_port();
    test_timeout();
    test_wrong_done();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
